pci_req_ctrl: RTL and testbench

Per-initiator bus-request controller on the agent side of the central PCI arbiter. It turns an internal transfer request from the initiator core into the active-low REQ# line that feeds one bit of the arbiter's `req` vector. It then watches the returned GNT# and bus-idle conditions to hand bus ownership to the core. While the bus is owned it runs the PCI latency timer and enforces the mandatory REQ# release after every transaction.

---
 rtl/pci_arb_pkg.sv | 16 +
 rtl/pci_lat_timer.sv | 30 +++
 rtl/pci_req_ctrl.sv | 116 +++++++++++
 tb/tb_pci_req_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_arb_pkg.sv
// Shared types and defaults for the PCI arbiter and its per-initiator request controllers.
package pci_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_START = 3'd2,
    ST_OWN   = 3'd3,
    ST_HOLD  = 3'd4
  } pci_req_state_e;

  localparam int PCI_LT_W        = 8;
  localparam int PCI_HOLD_CYCLES = 2;
  localparam int PCI_REQ_VEC_W   = 8;

endpackage

// File: rtl/pci_lat_timer.sv
// PCI latency timer: loadable down-counter that saturates at zero instead of wrapping.
module pci_lat_timer #(
  parameter int LT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [LT_W-1:0] value,
  input  logic            en,
  output logic            zero
);

  logic [LT_W-1:0] cnt_r;

  // Counter register; a load wins over a decrement in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {LT_W{1'b0}};
    end else if (load) begin
      cnt_r <= value;
    end else if (en && (cnt_r != {LT_W{1'b0}})) begin
      cnt_r <= cnt_r - LT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {LT_W{1'b0}});

endmodule

// File: rtl/pci_req_ctrl.sv
// Agent-side REQ#/GNT# controller: requests the bus, takes ownership on grant with an idle
// bus, runs the latency timer while owning, and forces a REQ# release gap after each transfer.
module pci_req_ctrl
  import pci_arb_pkg::*;
#(
  parameter int LT_W        = PCI_LT_W,
  parameter int HOLD_CYCLES = PCI_HOLD_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            xfer_req,
  input  logic            xfer_last,
  input  logic            gnt_n,
  input  logic            frame_n,
  input  logic            irdy_n,
  input  logic [LT_W-1:0] lat_timer,
  output logic            req_n,
  output logic            own_bus,
  output logic            xfer_ack,
  output logic            lt_expired
);

  localparam int HC_W = $clog2(HOLD_CYCLES + 1) + 1;

  pci_req_state_e  state_r;
  pci_req_state_e  state_nxt_s;
  logic [HC_W-1:0] hold_cnt_r;
  logic            hold_done_s;
  logic            bus_idle_s;
  logic            lt_zero_s;
  logic            req_n_r;
  logic            own_bus_r;
  logic            xfer_ack_r;
  logic            lt_expired_r;

  assign bus_idle_s  = frame_n & irdy_n;
  assign hold_done_s = (int'(hold_cnt_r) >= (HOLD_CYCLES - 1));

  pci_lat_timer #(.LT_W(LT_W)) u_lat_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state_r == ST_START),
    .value (lat_timer),
    .en    (state_r == ST_OWN),
    .zero  (lt_zero_s)
  );

  // Next-state decode; a withdrawn request beats a grant seen in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_req) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!xfer_req) begin
          state_nxt_s = ST_IDLE;
        end else if (!gnt_n && bus_idle_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_START: state_nxt_s = ST_OWN;
      ST_OWN: begin
        if (xfer_last) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_OWN;
        end
      end
      ST_HOLD: begin
        if (hold_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, hold counter, and outputs registered from the next state so they change only on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= {HC_W{1'b0}};
      req_n_r      <= 1'b1;
      own_bus_r    <= 1'b0;
      xfer_ack_r   <= 1'b0;
      lt_expired_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= (state_r == ST_HOLD) ? (hold_cnt_r + HC_W'(1)) : {HC_W{1'b0}};
      req_n_r    <= (state_nxt_s != ST_REQ);
      own_bus_r  <= (state_nxt_s == ST_START) || (state_nxt_s == ST_OWN);
      xfer_ack_r <= (state_nxt_s == ST_START);
      // Expiry is sticky for the rest of the ownership and drops as OWN is left.
      if ((state_r == ST_OWN) && (state_nxt_s == ST_OWN)) begin
        lt_expired_r <= lt_expired_r | (lt_zero_s & gnt_n);
      end else begin
        lt_expired_r <= 1'b0;
      end
    end
  end

  assign req_n      = req_n_r;
  assign own_bus    = own_bus_r;
  assign xfer_ack   = xfer_ack_r;
  assign lt_expired = lt_expired_r;

endmodule

// File: tb/tb_pci_req_ctrl.sv
// Self-checking bench for pci_req_ctrl: directed scenarios plus randomized traffic against a timestamp-style model.
module tb_pci_req_ctrl;

  localparam int LT_W = 8;
  localparam int HC   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            xfer_req = 1'b0;
  logic            xfer_last = 1'b0;
  logic            gnt_n = 1'b1;
  logic            frame_n = 1'b1;
  logic            irdy_n = 1'b1;
  logic [LT_W-1:0] lat_timer = 8'd0;
  logic            req_n, own_bus, xfer_ack, lt_expired;

  int errors = 0;
  int checks = 0;

  // Model: requesting / owning flags, cycles spent owning, remaining hold cycles, expiry flag.
  bit m_req, m_own, m_start, m_exp;
  int m_k, m_hold, m_l;

  always #5 clk = ~clk;

  pci_req_ctrl #(.LT_W(LT_W), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst_n(rst_n), .xfer_req(xfer_req), .xfer_last(xfer_last),
    .gnt_n(gnt_n), .frame_n(frame_n), .irdy_n(irdy_n), .lat_timer(lat_timer),
    .req_n(req_n), .own_bus(own_bus), .xfer_ack(xfer_ack), .lt_expired(lt_expired)
  );

  function automatic logic [3:0] exp_vec();
    return {~m_req, m_own, m_start, m_exp};
  endfunction

  task automatic model_reset();
    m_req = 0; m_own = 0; m_start = 0; m_exp = 0; m_k = 0; m_hold = 0; m_l = 0;
  endtask

  task automatic model_edge();
    if (m_own) begin
      if (m_start) begin
        m_start = 0; m_k = 0; m_l = int'(lat_timer);
      end else if (xfer_last) begin
        m_own = 0; m_hold = HC; m_exp = 0;
      end else begin
        if (m_k >= m_l && gnt_n) m_exp = 1;
        m_k++;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_req) begin
      if (!xfer_req) m_req = 0;
      else if (!gnt_n && frame_n && irdy_n) begin
        m_req = 0; m_own = 1; m_start = 1;
      end
    end else if (xfer_req) begin
      m_req = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply(input logic xr, input logic xl, input logic g, input logic f, input logic i);
    xfer_req = xr; xfer_last = xl; gnt_n = g; frame_n = f; irdy_n = i;
    step();
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    checks++;
    if ({req_n, own_bus, xfer_ack, lt_expired} !== 4'b1000) begin
      errors++; $display("FAIL reset_values: got %b want 1000", {req_n, own_bus, xfer_ack, lt_expired});
    end
    rst_n = 1'b1;
    lat_timer = 8'd9;
    apply(1, 0, 1, 1, 1);
    apply(1, 0, 0, 1, 1);
    apply(1, 0, 0, 1, 1);
    checks++;
    if (own_bus !== 1'b1) begin
      errors++; $display("FAIL reset_setup_own: got %b want 1", own_bus);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req_n !== 1'b1 || own_bus !== 1'b0) begin
      errors++; $display("FAIL reset_async: req_n=%b own_bus=%b want 1/0", req_n, own_bus);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 1, 1);
    checks++;
    if ({req_n, own_bus, xfer_ack, lt_expired} !== 4'b1000 || exp_vec() !== 4'b1000) begin
      errors++; $display("FAIL reset_idle: got %b want 1000", {req_n, own_bus, xfer_ack, lt_expired});
    end
  endtask

  task automatic test_basic_grant();
    int acks = 0;
    int hi = 0;
    lat_timer = 8'd20;
    apply(1, 0, 1, 1, 1);
    checks++;
    if (req_n !== 1'b0) begin
      errors++; $display("FAIL basic_req_latency: req_n=%b want 0", req_n);
    end
    apply(1, 0, 1, 1, 1);
    for (int c = 0; c < 6; c++) begin
      apply(1, 0, 0, 1, 1);
      if (xfer_ack === 1'b1) acks++;
      checks++;
      if ({req_n, own_bus, xfer_ack, lt_expired} !== exp_vec()) begin
        errors++; $display("FAIL basic_cycle%0d: got %b want %b", c, {req_n, own_bus, xfer_ack, lt_expired}, exp_vec());
      end
    end
    checks++;
    if (acks != 1 || own_bus !== 1'b1) begin
      errors++; $display("FAIL basic_ack_pulse: acks=%0d own_bus=%b want 1/1", acks, own_bus);
    end
    apply(0, 1, 0, 1, 1);
    checks++;
    if (own_bus !== 1'b0) begin
      errors++; $display("FAIL basic_release: own_bus=%b want 0", own_bus);
    end
    for (int c = 0; c < 3; c++) begin
      apply(0, 0, 0, 1, 1);
      if (req_n === 1'b1) hi++;
    end
    checks++;
    if (hi != 3) begin
      errors++; $display("FAIL basic_hold_high: high_cycles=%0d want 3", hi);
    end
  endtask

  task automatic test_busy_bus();
    apply(1, 0, 1, 1, 1);
    for (int c = 0; c < 3; c++) begin
      apply(1, 0, 0, 0, c[0]);
      checks++;
      if (own_bus !== 1'b0 || req_n !== 1'b0) begin
        errors++; $display("FAIL busy_wait%0d: own_bus=%b req_n=%b want 0/0", c, own_bus, req_n);
      end
    end
    apply(1, 0, 0, 1, 1);
    checks++;
    if (xfer_ack !== 1'b1 || own_bus !== 1'b1 || exp_vec() !== 4'b1110) begin
      errors++; $display("FAIL busy_start: ack=%b own=%b want 1/1", xfer_ack, own_bus);
    end
    apply(0, 0, 0, 1, 1);
    apply(0, 1, 0, 1, 1);
    repeat (3) apply(0, 0, 1, 1, 1);
  endtask

  task automatic test_lat_expiry(input int l);
    int n = 0;
    lat_timer = l[LT_W-1:0];
    apply(1, 0, 1, 1, 1);
    apply(1, 0, 0, 1, 1);
    apply(0, 0, 0, 1, 1);
    for (int c = 1; c <= 20; c++) begin
      apply(0, 0, 1, 1, 1);
      checks++;
      if ({req_n, own_bus, xfer_ack, lt_expired} !== exp_vec()) begin
        errors++; $display("FAIL expiry_L%0d_cycle%0d: got %b want %b", l, c, {req_n, own_bus, xfer_ack, lt_expired}, exp_vec());
      end
      if (lt_expired === 1'b1) begin
        n = c;
        break;
      end
    end
    checks++;
    if (n != l + 1) begin
      errors++; $display("FAIL expiry_L%0d_latency: rose after %0d cycles want %0d", l, n, l + 1);
    end
    apply(0, 0, 0, 1, 1);
    checks++;
    if (lt_expired !== 1'b1) begin
      errors++; $display("FAIL expiry_L%0d_sticky: got %b want 1", l, lt_expired);
    end
    apply(0, 1, 0, 1, 1);
    checks++;
    if (lt_expired !== 1'b0 || own_bus !== 1'b0) begin
      errors++; $display("FAIL expiry_L%0d_clear: flag=%b own=%b want 0/0", l, lt_expired, own_bus);
    end
    repeat (3) apply(0, 0, 1, 1, 1);
  endtask

  task automatic test_withdraw();
    apply(1, 0, 1, 1, 1);
    apply(0, 0, 0, 1, 1);
    checks++;
    if (req_n !== 1'b1 || xfer_ack !== 1'b0 || own_bus !== 1'b0) begin
      errors++; $display("FAIL withdraw: req_n=%b ack=%b own=%b want 1/0/0", req_n, xfer_ack, own_bus);
    end
    apply(0, 0, 0, 1, 1);
    checks++;
    if (own_bus !== 1'b0 || exp_vec() !== 4'b1000) begin
      errors++; $display("FAIL no_parking: own_bus=%b want 0", own_bus);
    end
  endtask

  task automatic test_back_to_back();
    int hi = 0;
    int early = 0;
    lat_timer = 8'd30;
    apply(1, 0, 0, 1, 1);
    apply(1, 0, 0, 1, 1);
    apply(1, 0, 0, 1, 1);
    apply(1, 1, 1, 1, 1);
    for (int c = 0; c < 10; c++) begin
      apply(1, 0, 1, 1, 1);
      if (req_n === 1'b0) break;
      hi++;
    end
    checks++;
    if (hi != 2) begin
      errors++; $display("FAIL b2b_gap: req_n high %0d cycles after release edge want 2 (3 incl. release)", hi);
    end
    repeat (3) begin
      apply(1, 0, 1, 1, 1);
      if (xfer_ack === 1'b1) early++;
    end
    checks++;
    if (early != 0 || req_n !== 1'b0) begin
      errors++; $display("FAIL b2b_no_early_ack: acks=%0d req_n=%b want 0/0", early, req_n);
    end
    apply(1, 0, 0, 1, 1);
    checks++;
    if (xfer_ack !== 1'b1 || exp_vec() !== 4'b1110) begin
      errors++; $display("FAIL b2b_second_ack: ack=%b want 1", xfer_ack);
    end
    apply(0, 0, 0, 1, 1);
    apply(0, 1, 0, 1, 1);
    repeat (3) apply(0, 0, 1, 1, 1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) lat_timer = LT_W'($urandom_range(0, 6));
      apply($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      checks++;
      if ({req_n, own_bus, xfer_ack, lt_expired} !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %b want %b", c, {req_n, own_bus, xfer_ack, lt_expired}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_busy_bus();
    test_lat_expiry(4);
    test_lat_expiry(0);
    test_withdraw();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
